// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame geometry and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_BYTES_PER_WORD = 4;

    localparam logic UART_LINE_IDLE  = 1'b1;
    localparam logic UART_LINE_START = 1'b0;
    localparam logic UART_LINE_STOP  = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero by clear.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic fpga_clk,
    input  logic fpga_rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            count_reg <= '0;
        end else if (clear || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Serialises 32-bit words as four UART frames, LSB byte first.
// Define UART_WORD_TX_PARITY_EN for 8E1 frames; default is 8N1.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        tx
);

    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam int BYTE_W = $clog2(UART_BYTES_PER_WORD);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(UART_BYTES_PER_WORD - 1);

    uart_tx_state_t    state_reg;
    logic [31:0]       shift_reg;
    logic [BYTE_W-1:0] byte_idx_reg;
    logic [BIT_W-1:0]  bit_idx_reg;
    logic              tx_reg;
    logic              done_reg;
    logic              tick;
`ifdef UART_WORD_TX_PARITY_EN
    logic              parity_reg;
`endif

    // Timer sits at zero in IDLE so the start bit is a full bit period from accept.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .fpga_clk (fpga_clk),
        .fpga_rst (fpga_rst),
        .clear    (state_reg == IDLE),
        .tick     (tick)
    );

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= UART_LINE_IDLE;
            done_reg     <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= UART_LINE_IDLE;
                    if (word_valid_i) begin
                        shift_reg    <= word_i;
                        byte_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= UART_LINE_START;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_reg      <= shift_reg[0];
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
`ifdef UART_WORD_TX_PARITY_EN
                        parity_reg  <= even_parity(shift_reg[UART_DATA_BITS-1:0]);
`endif
                    end
                end
                DATA: begin
                    if (tick) begin
                        // After eight shifts the next byte sits in the low bits.
                        shift_reg <= {1'b0, shift_reg[31:1]};
                        if (bit_idx_reg == LAST_BIT) begin
                            bit_idx_reg <= '0;
`ifdef UART_WORD_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= PARITY;
`else
                            tx_reg    <= UART_LINE_STOP;
                            state_reg <= STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_WORD_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_reg    <= UART_LINE_STOP;
                        state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (byte_idx_reg == LAST_BYTE) begin
                            tx_reg    <= UART_LINE_IDLE;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            tx_reg       <= UART_LINE_START;
                            state_reg    <= START;
                        end
                    end
                end
                default: begin
                    tx_reg    <= UART_LINE_IDLE;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign word_ready_o = (state_reg == IDLE);
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = done_reg;
    assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: stimulus queues expected words, a line decoder checks tx.
module tb_uart_word_tx;

    localparam int CPB = 4;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int WORD_CYCLES = 4 * F * CPB;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b0;
    logic [31:0] word_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_pulses = 0;
    logic [31:0] exp_q[$];

    uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
        .fpga_clk     (fpga_clk),
        .fpga_rst     (fpga_rst),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .tx           (tx)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(posedge fpga_clk) begin
        cyc <= cyc + 1;
        if (fpga_rst && word_valid_i && word_ready_o)
            accept_cyc <= cyc + 1;
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_WORD_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Line decoder: samples every cycle, one frame vector per byte, compared at its stop bit.
    initial begin
        bit          active = 0;
        logic [31:0] exp_word = '0;
        logic [10:0] rx_frame = '0;
        bit          glitch = 0;
        int          bitpos = 0;
        int          sub = 0;
        int          byte_n = 0;
        forever begin
            @(negedge fpga_clk);
            if (!fpga_rst) begin
                active = 0;
                continue;
            end
            if (!active) begin
                if (tx !== 1'b0) continue;
                active = 1;
                bitpos = 0; sub = 0; byte_n = 0; glitch = 0; rx_frame = '0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start: got start bit at cycle %0d want no word", cyc);
                    exp_word = '0;
                end else begin
                    exp_word = exp_q.pop_front();
                    check("start_latency", 32'(cyc), 32'(accept_cyc));
                end
            end
            if (sub == 0) rx_frame[bitpos] = tx;
            else if (tx !== rx_frame[bitpos]) glitch = 1;
            if (sub == CPB - 1) begin
                sub = 0;
                if (bitpos == F - 1) begin
                    total++;
                    if (glitch || rx_frame !== exp_frame(exp_word[8*byte_n +: 8])) begin
                        bad++;
                        $display("FAIL frame word %h byte %0d: got %h glitch=%0d want %h",
                                 exp_word, byte_n, rx_frame, glitch, exp_frame(exp_word[8*byte_n +: 8]));
                    end else begin
                        $display("ok   frame word %h byte %0d: %h", exp_word, byte_n, rx_frame);
                    end
                    bitpos = 0; glitch = 0; rx_frame = '0;
                    byte_n++;
                    if (byte_n == 4) active = 0;
                end else begin
                    bitpos++;
                end
            end else begin
                sub++;
            end
        end
    end

    // done_o monitor: each pulse must land exactly one word duration after accept.
    initial begin
        forever begin
            @(negedge fpga_clk);
            if (fpga_rst && done_o === 1'b1) begin
                done_pulses++;
                check("done_time", 32'(cyc - accept_cyc), 32'(WORD_CYCLES));
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        @(negedge fpga_clk);
        word_i = w;
        word_valid_i = 1'b1;
        exp_q.push_back(w);
        @(negedge fpga_clk);
        word_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (done_o === 1'b1) break;
            @(negedge fpga_clk);
        end
        if (i == 2000) begin
            total++; bad++;
            $display("FAIL %s: got no done_o within 2000 cycles want done_o", name);
        end
        @(negedge fpga_clk);
    endtask

    initial begin
        int i;
        repeat (3) @(posedge fpga_clk);
        @(negedge fpga_clk);
        fpga_rst = 1'b1;
        @(negedge fpga_clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(word_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);

        // Single word.
        send_word(32'h12345678);
        check("busy_after_accept", 32'(busy_o), 32'd1);
        wait_done("single_done");

        // Valid asserted mid-word must be ignored.
        send_word(32'hCAFE0001);
        repeat (40) @(negedge fpga_clk);
        word_i = 32'hDEADBEEF;
        word_valid_i = 1'b1;
        repeat (20) @(negedge fpga_clk);
        check("ignored_ready", 32'(word_ready_o), 32'd0);
        word_valid_i = 1'b0;
        wait_done("ignored_done");

        // Back-to-back words with valid held high.
        @(negedge fpga_clk);
        word_i = 32'hA5A5A5A5;
        word_valid_i = 1'b1;
        exp_q.push_back(32'hA5A5A5A5);
        for (i = 0; i < 10 && word_ready_o; i++) @(negedge fpga_clk);
        word_i = 32'hFFFFFFFF;
        exp_q.push_back(32'hFFFFFFFF);
        for (i = 0; i < 2000 && done_o !== 1'b1; i++) @(negedge fpga_clk);
        check("b2b_first_done", 32'(done_o), 32'd1);
        @(negedge fpga_clk);
        word_valid_i = 1'b0;
        check("b2b_start_tx", 32'(tx), 32'd0);
        check("b2b_start_ready", 32'(word_ready_o), 32'd0);
        wait_done("b2b_done");

        // Asynchronous reset while byte 2 (0x00) is on the line.
        send_word(32'h3C00C3A5);
        repeat (94) @(negedge fpga_clk);
        check("pre_rst_tx", 32'(tx), 32'd0);
        #1 fpga_rst = 1'b0;
        #1 check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_ready", 32'(word_ready_o), 32'd1);
        repeat (3) @(negedge fpga_clk);
        fpga_rst = 1'b1;
        send_word(32'h89ABCDEF);
        wait_done("after_rst_done");

        // Parity reference word: bytes 0x78 (parity 0) and 0x01 (parity 1).
        send_word(32'h00000178);
        wait_done("parity_word_done");

        repeat (10) @(negedge fpga_clk);
        check("done_count", 32'(done_pulses), 32'd6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_tx_idle", 32'(tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
